// File: rtl/game_tick_gen.sv
// ----------------------------------------------------------------------------
// game_tick_gen
//
// Derives game-rate tick pulses from the VGA pixel scan. The end of a frame is
// the first clock on which the scan sits on the last pixel (MAX_H, MAX_V). Each
// frame end can advance NUM_CH independent channels, and every channel ticks
// once per i_div[c] frames. Pause freezes all channels, single-step forces one
// tick on all of them, and sync-clear rewinds all channels. None of these
// controls affect frame detection.
//
// Ports:
//   i_clock        system clock
//   i_reset        asynchronous, active-high reset
//   i_x, i_y       current pixel address from the VGA timing generator
//   i_div          per-channel frames-per-tick, channel c at [c*DIV_W +: DIV_W]
//                  (0 behaves as 1)
//   i_pause        level: while high, channels hold and do not tick
//   i_step         rising edge while paused ticks every channel once
//   i_sync_clr     synchronous clear of all channel counters, no tick
//   o_frame        one-cycle pulse per frame end
//   o_tick         one-cycle tick pulse per channel
//   o_frame_count  frames seen since reset (wraps)
//   o_tick_count   channel-0 ticks since reset (wraps)
// ----------------------------------------------------------------------------
module game_tick_gen #(
    parameter int COORD_W = 10,
    parameter int MAX_H   = 639,
    parameter int MAX_V   = 479,
    parameter int NUM_CH  = 2,
    parameter int DIV_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [COORD_W-1:0]        i_x,
    input  logic [COORD_W-1:0]        i_y,
    input  logic [NUM_CH*DIV_W-1:0]   i_div,
    input  logic                      i_pause,
    input  logic                      i_step,
    input  logic                      i_sync_clr,
    output logic                      o_frame,
    output logic [NUM_CH-1:0]         o_tick,
    output logic [CNT_W-1:0]          o_frame_count,
    output logic [CNT_W-1:0]          o_tick_count
);

    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(MAX_H);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(MAX_V);

    logic                 match;
    logic                 match_q;
    logic                 step_q;
    logic                 frame_event;
    logic                 step_edge;

    logic [DIV_W-1:0]     div_last [NUM_CH];
    logic [DIV_W-1:0]     cnt_q    [NUM_CH];
    logic [DIV_W-1:0]     cnt_d    [NUM_CH];

    logic                 frame_q,       frame_d;
    logic [NUM_CH-1:0]    tick_q,        tick_d;
    logic [CNT_W-1:0]     frame_count_q, frame_count_d;
    logic [CNT_W-1:0]     tick_count_q,  tick_count_d;

    // The scan can dwell on the last pixel for several clocks; only the first
    // of them counts as a frame end.
    assign match       = (i_x == LAST_X) && (i_y == LAST_Y);
    assign frame_event = match && !match_q;
    assign step_edge   = i_step && !step_q && i_pause;

    // Last counter value before a channel is due: eff_div - 1, where a
    // programmed divisor of 0 is treated as 1.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            div_last[c] = '0;
            if (i_div[c*DIV_W +: DIV_W] != '0) begin
                div_last[c] = i_div[c*DIV_W +: DIV_W] - DIV_W'(1);
            end
        end
    end

    // Priority per channel: sync-clear, then step, then a frame advance.
    // A step landing on a frame end wins outright, so a channel ticks once.
    // The >= compare lets a channel whose divisor was lowered below its current
    // count tick on the very next frame end instead of wrapping around.
    always_comb begin
        tick_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (i_sync_clr) begin
                cnt_d[c] = '0;
            end else if (step_edge) begin
                cnt_d[c]  = '0;
                tick_d[c] = 1'b1;
            end else if (frame_event && !i_pause) begin
                if (cnt_q[c] >= div_last[c]) begin
                    cnt_d[c]  = '0;
                    tick_d[c] = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c] + DIV_W'(1);
                end
            end
        end
    end

    always_comb begin
        frame_d       = frame_event;
        frame_count_d = frame_count_q + CNT_W'(frame_event);
        tick_count_d  = tick_count_q + CNT_W'(tick_d[0]);
    end

    // match_q resets high so that a scan parked on the last pixel across reset
    // release is not mistaken for a new frame end.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            match_q       <= 1'b1;
            step_q        <= 1'b0;
            frame_q       <= 1'b0;
            tick_q        <= '0;
            frame_count_q <= '0;
            tick_count_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            match_q       <= match;
            step_q        <= i_step;
            frame_q       <= frame_d;
            tick_q        <= tick_d;
            frame_count_q <= frame_count_d;
            tick_count_q  <= tick_count_d;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign o_frame       = frame_q;
    assign o_tick        = tick_q;
    assign o_frame_count = frame_count_q;
    assign o_tick_count  = tick_count_q;

endmodule
